baud_rate_gen: RTL and testbench

Parametrised, runtime-programmable baud/oversample tick generator for the UART. It divides the system clock by an integer-plus-fractional divisor to produce an oversample strobe `tick_os`, and divides that by `OVERSAMPLE` to produce `baud_tick`. It also provides glitch-free divisor reload, an enable, and a phase resync for the RX start-bit edge. It sits between the clock domain and the UART TX/RX engines, and a CSR block drives its divisor inputs.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/frac_div.sv | 63 ++++++
 rtl/baud_rate_gen.sv | 131 +++++++++++++
 tb/tb_baud_rate_gen.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default clocking constants, the divisor struct and
// the reset-divisor computation used by baud_rate_gen.
package uart_pkg;

  localparam int CLK_FREQ_HZ_DEF = 100_000_000;
  localparam int BAUD_DEF        = 115200;
  localparam int OVERSAMPLE_DEF  = 16;

  // Wide enough for any DIV_W/FRAC_W a user instantiates; callers slice.
  typedef struct packed {
    logic [31:0] div_int;
    logic [15:0] div_frac;
  } div_t;

  // Reset divisor in clocks per oversample tick. With the fractional path the
  // value is rounded to the nearest 1/2^frac_w clock, otherwise truncated.
  function automatic div_t calc_rst_div(input int clk_hz, input int baud,
                                        input int oversample, input int frac_w,
                                        input bit frac_en);
    longint den;
    longint num;
    longint q;
    div_t   d;
    den = longint'(baud) * longint'(oversample);
    if (frac_en) begin
      num        = longint'(clk_hz) <<< frac_w;
      q          = (longint'(2) * num + den) / (longint'(2) * den);
      d.div_int  = 32'(q >>> frac_w);
      d.div_frac = 16'(q & ((longint'(1) <<< frac_w) - longint'(1)));
    end else begin
      d.div_int  = 32'(longint'(clk_hz) / den);
      d.div_frac = '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/frac_div.sv
// Integer-plus-fractional clock divider core: a down-counter that reloads at
// each period end, stretched by one clock whenever the fractional accumulator
// carries. The accumulator only exists when BAUD_RATE_GEN_FRAC_EN is defined.
module frac_div
  import uart_pkg::*;
#(
  parameter int               DIV_W   = 16,
  parameter int               FRAC_W  = 4,
  parameter logic [DIV_W-1:0] RST_CNT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,     // count this cycle
  input  logic              restart,     // reload to eff_int-1, clear phase
  input  logic [DIV_W-1:0]  eff_int,     // divisor (>=1) for the next period
  input  logic [FRAC_W-1:0] frac,        // fractional part added per period
  output logic              period_end   // raw strobe: reload happens now
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic             carry;

  assign period_end = advance && (cnt == '0);

`ifdef BAUD_RATE_GEN_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, frac};
  assign carry   = acc_sum[FRAC_W];

  // Fractional accumulator: advances once per period, wraps mod 2^FRAC_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (restart) begin
      acc <= '0;
    end else if (period_end) begin
      acc <= acc_sum[FRAC_W-1:0];
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^frac;
  assign carry       = 1'b0;
`endif

  // Period down-counter; a carry lengthens the new period by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= RST_CNT;
    end else if (restart) begin
      cnt <= eff_int - ONE;
    end else if (period_end) begin
      cnt <= eff_int - ONE + DIV_W'(carry);
    end else if (advance) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/baud_rate_gen.sv
// Runtime-programmable oversample/baud tick generator for the UART.
// Optional fractional divisor support: define BAUD_RATE_GEN_FRAC_EN.
// A loaded divisor waits in a shadow register until the current period ends,
// unless the generator is disabled or resynced, in which case it applies at
// once. resync restarts the tick phase for RX start-bit alignment.
module baud_rate_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
  parameter int BAUD        = BAUD_DEF,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,   // must be >= 2
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              tick_os,
  output logic              baud_tick,
  output logic              div_pending
);

`ifdef BAUD_RATE_GEN_FRAC_EN
  localparam bit FRAC_EN = 1'b1;
`else
  localparam bit FRAC_EN = 1'b0;
`endif

  localparam div_t              RST_DIV  = calc_rst_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE,
                                                        FRAC_W, FRAC_EN);
  localparam logic [DIV_W-1:0]  RST_INT  = RST_DIV.div_int[DIV_W-1:0];
  localparam logic [FRAC_W-1:0] RST_FRAC = RST_DIV.div_frac[FRAC_W-1:0];
  localparam logic [DIV_W-1:0]  RST_EFF  = (RST_INT == '0) ? DIV_W'(1) : RST_INT;
  localparam logic [DIV_W-1:0]  RST_CNT  = RST_EFF - DIV_W'(1);
  localparam int                OS_W     = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;
  logic              pending_q;
  logic [DIV_W-1:0]  sel_int;
  logic [FRAC_W-1:0] sel_frac;
  logic [DIV_W-1:0]  eff_int;
  logic              advance;
  logic              restart;
  logic              period_end;
  logic [OS_W-1:0]   os_cnt;

  // Divisor that takes effect if the period reloads this cycle: a load in
  // this cycle beats an older pending shadow, which beats the active value.
  always_comb begin
    sel_int  = act_int;
    sel_frac = act_frac;
    if (div_load) begin
      sel_int  = div_int;
      sel_frac = div_frac;
    end else if (pending_q) begin
      sel_int  = sh_int;
      sel_frac = sh_frac;
    end
    eff_int = (sel_int == '0) ? DIV_W'(1) : sel_int;
    advance = enable & ~resync;
    restart = resync | (div_load & ~enable);
  end

  // Shadow/active divisor registers; any reload point promotes the selection.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_int   <= RST_INT;
      act_frac  <= RST_FRAC;
      sh_int    <= RST_INT;
      sh_frac   <= RST_FRAC;
      pending_q <= 1'b0;
    end else begin
      if (div_load) begin
        sh_int  <= div_int;
        sh_frac <= div_frac;
      end
      if (restart || period_end) begin
        act_int   <= sel_int;
        act_frac  <= sel_frac;
        pending_q <= 1'b0;
      end else if (div_load) begin
        pending_q <= 1'b1;
      end
    end
  end

  frac_div #(
    .DIV_W   (DIV_W),
    .FRAC_W  (FRAC_W),
    .RST_CNT (RST_CNT)
  ) u_frac_div (
    .clk        (clk),
    .reset      (reset),
    .advance    (advance),
    .restart    (restart),
    .eff_int    (eff_int),
    .frac       (sel_frac),
    .period_end (period_end)
  );

  // Registered strobes and the oversample position within the current bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_os   <= 1'b0;
      baud_tick <= 1'b0;
      os_cnt    <= '0;
    end else if (resync) begin
      tick_os   <= 1'b0;
      baud_tick <= 1'b0;
      os_cnt    <= '0;
    end else if (period_end) begin
      tick_os   <= 1'b1;
      baud_tick <= (os_cnt == OS_LAST);
      os_cnt    <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
    end else begin
      tick_os   <= 1'b0;
      baud_tick <= 1'b0;
    end
  end

  assign div_pending = pending_q;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Self-checking bench for baud_rate_gen. Expected tick_os/baud_tick cycle
// numbers are pushed to queues as stimulus is planned and popped as the DUT
// produces them. Follows BAUD_RATE_GEN_FRAC_EN like the design.
module tb_baud_rate_gen;

  localparam int OS = 16;
`ifdef BAUD_RATE_GEN_FRAC_EN
  localparam bit FRAC_EN = 1'b1;
`else
  localparam bit FRAC_EN = 1'b0;
`endif
  localparam int RST_INT  = 54;
  localparam int RST_FRAC = FRAC_EN ? 4 : 0;
  localparam int BIT4_SUM = FRAC_EN ? 3472 : 3456;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        resync;
  logic        tick_os;
  logic        baud_tick;
  logic        div_pending;

  baud_rate_gen dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .div_load    (div_load),
    .resync      (resync),
    .tick_os     (tick_os),
    .baud_tick   (baud_tick),
    .div_pending (div_pending)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_tick_q[$];
  logic [31:0] exp_baud_q[$];
  logic [31:0] obs_baud_q[$];
  int checks = 0;
  int errors = 0;
  int obs_ticks = 0;

  // reference state: next tick edge, accumulator, oversample index, divisor
  int m_next, m_acc, m_os, m_int, m_frac;

  task automatic plan(input int n);
    int sum;
    for (int i = 0; i < n; i++) begin
      exp_tick_q.push_back(32'(m_next));
      if (m_os == OS - 1) exp_baud_q.push_back(32'(m_next));
      m_os   = (m_os + 1) % OS;
      sum    = m_acc + m_frac;
      m_next = m_next + ((m_int < 1) ? 1 : m_int) + sum / 16;
      m_acc  = sum % 16;
    end
  endtask

  // Advance one cycle and score whatever the DUT emitted on it.
  task automatic clk_step();
    logic [31:0] e;
    @(negedge clk);
    while (exp_tick_q.size() > 0 && cyc > int'(exp_tick_q[0])) begin
      e = exp_tick_q.pop_front();
      checks++; errors++;
      $display("FAIL tick_missing: got no tick_os, required at cycle %0d (now %0d)", e, cyc);
    end
    while (exp_baud_q.size() > 0 && cyc > int'(exp_baud_q[0])) begin
      e = exp_baud_q.pop_front();
      checks++; errors++;
      $display("FAIL baud_missing: got no baud_tick, required at cycle %0d (now %0d)", e, cyc);
    end
    if (tick_os !== 1'b0) begin
      obs_ticks++; checks++;
      if (exp_tick_q.size() == 0) begin
        errors++;
        $display("FAIL tick_unexpected: tick_os=%b at cycle %0d, required 0", tick_os, cyc);
      end else begin
        e = exp_tick_q.pop_front();
        if (tick_os !== 1'b1 || cyc !== int'(e)) begin
          errors++;
          $display("FAIL tick_time: tick_os=%b at cycle %0d, required at cycle %0d", tick_os, cyc, e);
        end
      end
    end
    if (baud_tick !== 1'b0) begin
      obs_baud_q.push_back(32'(cyc));
      checks++;
      if (exp_baud_q.size() == 0) begin
        errors++;
        $display("FAIL baud_unexpected: baud_tick=%b at cycle %0d, required 0", baud_tick, cyc);
      end else begin
        e = exp_baud_q.pop_front();
        if (baud_tick !== 1'b1 || tick_os !== 1'b1 || cyc !== int'(e)) begin
          errors++;
          $display("FAIL baud_time: baud_tick=%b tick_os=%b at cycle %0d, required both at %0d",
                   baud_tick, tick_os, cyc, e);
        end
      end
    end
  endtask

  task automatic steps(input int n);
    repeat (n) clk_step();
  endtask

  task automatic drain(input int budget);
    int b = budget;
    while ((exp_tick_q.size() > 0 || exp_baud_q.size() > 0) && b > 0) begin
      clk_step();
      b--;
    end
    checks++;
    if (exp_tick_q.size() != 0 || exp_baud_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d ticks / %0d bauds outstanding, required 0",
               exp_tick_q.size(), exp_baud_q.size());
      exp_tick_q.delete();
      exp_baud_q.delete();
    end
  endtask

  task automatic model_reset(input int rel_cyc);
    m_next = rel_cyc + RST_INT;
    m_acc  = 0;
    m_os   = 0;
    m_int  = RST_INT;
    m_frac = RST_FRAC;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; div_load = 1'b0; resync = 1'b0;
    div_int = 16'(RST_INT); div_frac = 4'd4;
    for (int i = 0; i < 5; i++) begin
      clk_step();
      checks++;
      if ({tick_os, baud_tick, div_pending} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs: tick/baud/pending=%b in reset cycle %0d, required 000",
                 {tick_os, baud_tick, div_pending}, i);
      end
    end
    reset = 1'b0;
    model_reset(cyc);
    obs_baud_q.delete();
    plan(80);
    drain(80 * 60);
    checks++;
    if (obs_baud_q.size() != 5) begin
      errors++;
      $display("FAIL baud_count: %0d baud_ticks over 80 ticks, required 5", obs_baud_q.size());
    end else if (int'(obs_baud_q[4] - obs_baud_q[0]) != BIT4_SUM) begin
      errors++;
      $display("FAIL baud_spacing: 4-bit span %0d clocks, required %0d",
               obs_baud_q[4] - obs_baud_q[0], BIT4_SUM);
    end
  endtask

  task automatic test_resync();
    int t;
    steps(7);
    resync = 1'b1;
    clk_step();
    resync = 1'b0;
    t = cyc;
    m_next = t + ((m_int < 1) ? 1 : m_int);
    m_acc  = 0;
    m_os   = 0;
    plan(17);
    drain(20 * 60);
  endtask

  task automatic test_enable();
    int n0;
    steps(10);
    enable = 1'b0;
    n0 = obs_ticks;
    steps(100);
    enable = 1'b1;
    checks++;
    if (obs_ticks != n0 || {tick_os, baud_tick} !== 2'b00) begin
      errors++;
      $display("FAIL enable_hold: %0d ticks while disabled, outputs=%b, required 0 and 00",
               obs_ticks - n0, {tick_os, baud_tick});
    end
    m_next = m_next + 100;
    plan(20);
    drain(25 * 60);
  endtask

  task automatic test_load_pending();
    int b;
    steps(20);
    div_int = 16'd10; div_frac = 4'd0; div_load = 1'b1;
    clk_step();
    div_load = 1'b0;
    div_int  = 16'($urandom_range(100, 200));
    div_frac = 4'($urandom_range(0, 15));
    checks++;
    if (div_pending !== 1'b1) begin
      errors++;
      $display("FAIL pending_set: div_pending=%b after load, required 1", div_pending);
    end
    b = m_next;
    m_int = 10; m_frac = 0;
    plan(20);
    while (cyc < b - 1) clk_step();
    checks++;
    if (div_pending !== 1'b1) begin
      errors++;
      $display("FAIL pending_hold: div_pending=%b before boundary, required 1", div_pending);
    end
    clk_step();
    checks++;
    if (div_pending !== 1'b0) begin
      errors++;
      $display("FAIL pending_clear: div_pending=%b at boundary, required 0", div_pending);
    end
    drain(25 * 60);
  endtask

  task automatic test_load_frac();
    steps(3);
    div_int = 16'd54; div_frac = 4'd4; div_load = 1'b1;
    clk_step();
    div_load = 1'b0;
    m_int = 54; m_frac = FRAC_EN ? 4 : 0;
    plan(9);
    drain(12 * 60);
  endtask

  task automatic test_resync_load();
    steps(5);
    div_int = 16'd20; div_frac = 4'd0; div_load = 1'b1; resync = 1'b1;
    clk_step();
    div_load = 1'b0; resync = 1'b0;
    checks++;
    if (div_pending !== 1'b0) begin
      errors++;
      $display("FAIL resync_load_pending: div_pending=%b, required 0", div_pending);
    end
    m_int = 20; m_frac = 0;
    m_next = cyc + 20; m_acc = 0; m_os = 0;
    plan(18);
    drain(20 * 30);
  endtask

  task automatic test_load_disabled_div1();
    int f;
    steps(3);
    enable = 1'b0;
    clk_step();
    div_int = 16'd1; div_frac = 4'd0; div_load = 1'b1;
    clk_step();
    div_load = 1'b0;
    checks++;
    if (div_pending !== 1'b0 || tick_os !== 1'b0) begin
      errors++;
      $display("FAIL disabled_load: pending=%b tick_os=%b, required 0 0", div_pending, tick_os);
    end
    steps(2);
    enable = 1'b1;
    f = cyc + 1;
    m_int = 1; m_frac = 0; m_acc = 0;
    m_next = f;
    plan(31);
    while (cyc < f + 30) clk_step();
    drain(5);
  endtask

  task automatic test_mid_reset();
    reset = 1'b1; div_int = 16'd7; div_load = 1'b1; resync = 1'b1;
    clk_step();
    div_load = 1'b0; resync = 1'b0;
    checks++;
    if ({tick_os, baud_tick, div_pending} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset: tick/baud/pending=%b, required 000",
               {tick_os, baud_tick, div_pending});
    end
    steps(2);
    reset = 1'b0;
    model_reset(cyc);
    plan(18);
    drain(20 * 60);
    checks++;
    if (div_pending !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_pending: div_pending=%b, required 0", div_pending);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; div_load = 1'b0; resync = 1'b0;
    div_int = '0; div_frac = '0;
    test_reset();
    test_resync();
    test_enable();
    test_load_pending();
    test_load_frac();
    test_resync_load();
    test_load_disabled_div1();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
